uart_word_rx: RTL and testbench

- Serial receive front-end that assembles four UART bytes into one 32-bit matrix word.
- Sits directly upstream of the top-level edit path; drives the word latched into matrix A/B while in an edit state.
- Raises a full flag once the word is complete.
- Accepts a one-cycle clear pulse, issued on edit entry or the "up" key, to start a fresh word.

---
 rtl/uart_word_rx.sv | 204 ++++++++++++++++++++
 tb/tb_uart_word_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 UART receive front-end that packs four bytes into a
// 32-bit word, first byte in word[31:24]. A 2-flop synchronizer feeds a
// tick-driven receive FSM. Accepted bytes shift into the word buffer until
// four are held, and then rx_full is raised. A one-cycle clear pulse empties
// the buffer and leaves any frame in flight untouched.
// Optional build macro UART_PARITY_EN selects 8E1 framing and adds the
// parity_err output.
module uart_word_rx #(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 9600,
   parameter int OVS    = 16
) (
   input  logic        CLK_50M,
   input  logic        reset,
   input  logic        clear,
   input  logic        rx,
   output logic        rx_full,
   output logic [31:0] word,
   output logic        byte_valid,
`ifdef UART_PARITY_EN
   output logic        parity_err,
`endif
   output logic        frame_err
);

   localparam int DIV = CLK_HZ / (BAUD * OVS);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW  = $clog2(OVS + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [SW-1:0] MID_LAST  = SW'(OVS / 2 - 1);
   localparam logic [SW-1:0] BIT_LAST  = SW'(OVS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } state_t;

   state_t          state;
   logic [1:0]      rx_sync;
   logic            rx_prev;
   logic            rx_s;
   logic            rx_fall;
   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic [SW-1:0]   smp_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic [2:0]      cnt;
   logic            stop_smp;
   logic            par_bad;
   logic            byte_ok;
`ifdef UART_PARITY_EN
   logic            par_bit;
`endif

   assign rx_s     = rx_sync[1];
   assign rx_fall  = rx_prev & ~rx_s;
   assign tick     = (tick_cnt == TICK_LAST);
   // The stop bit is sampled on this cycle; buffer acceptance keys off it.
   assign stop_smp = (state == STOP) && tick && (smp_cnt == BIT_LAST);
`ifdef UART_PARITY_EN
   assign par_bad  = ^{shreg, par_bit};
`else
   assign par_bad  = 1'b0;
`endif
   assign byte_ok  = rx_s & ~par_bad;

   // Two-flop synchronizer plus one delayed copy for falling-edge detection.
   always_ff @(posedge CLK_50M or negedge reset) begin
      if (!reset) begin
         rx_sync <= 2'b11;
         rx_prev <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[0], rx};
         rx_prev <= rx_sync[1];
      end
   end

   // Free-running oversample divider, one-cycle tick every DIV clocks.
   always_ff @(posedge CLK_50M or negedge reset) begin
      if (!reset)
         tick_cnt <= '0;
      else if (tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + 1'b1;
   end

   // Receive FSM: start validation, mid-bit data sampling, stop/parity checks.
   always_ff @(posedge CLK_50M or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         smp_cnt   <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         parity_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (rx_fall) begin
                  state   <= START;
                  smp_cnt <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if (smp_cnt == MID_LAST) begin
                     smp_cnt <= '0;
                     bit_idx <= '0;
                     // A line that is high again at mid-start is a glitch.
                     state   <= rx_s ? IDLE : DATA;
                  end else begin
                     smp_cnt <= smp_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (smp_cnt == BIT_LAST) begin
                     smp_cnt        <= '0;
                     shreg[bit_idx] <= rx_s;
                     if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                     end
                  end else begin
                     smp_cnt <= smp_cnt + 1'b1;
                  end
               end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
               if (tick) begin
                  if (smp_cnt == BIT_LAST) begin
                     smp_cnt <= '0;
                     par_bit <= rx_s;
                     state   <= STOP;
                  end else begin
                     smp_cnt <= smp_cnt + 1'b1;
                  end
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  if (smp_cnt == BIT_LAST) begin
                     // Back to IDLE immediately so a following start edge
                     // half a bit later is not missed.
                     smp_cnt   <= '0;
                     state     <= IDLE;
                     frame_err <= ~rx_s;
`ifdef UART_PARITY_EN
                     parity_err <= par_bad;
`endif
                  end else begin
                     smp_cnt <= smp_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Word buffer: clear has priority, and good bytes are dropped once full.
   always_ff @(posedge CLK_50M or negedge reset) begin
      if (!reset) begin
         word       <= '0;
         cnt        <= '0;
         rx_full    <= 1'b0;
         byte_valid <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         if (clear) begin
            word    <= '0;
            cnt     <= '0;
            rx_full <= 1'b0;
         end else if (stop_smp && byte_ok && (cnt < 3'd4)) begin
            word       <= {word[23:0], shreg};
            cnt        <= cnt + 1'b1;
            rx_full    <= (cnt == 3'd3);
            byte_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: directed test of uart_word_rx. The clock is scaled so the
// divider is 4 and one bit lasts 64 clocks. Pulse outputs are counted by a
// negedge monitor, and the directed steps check those counts and the word.
module tb_uart_word_rx;

   localparam int CLK_HZ = 614400;
   localparam int BAUD   = 9600;
   localparam int OVS    = 16;
   localparam int DIV    = CLK_HZ / (BAUD * OVS);
   localparam int BIT    = DIV * OVS;

   logic        CLK_50M = 1'b0;
   logic        reset   = 1'b0;
   logic        clear   = 1'b0;
   logic        rx      = 1'b1;
   logic        rx_full;
   logic [31:0] word;
   logic        byte_valid;
   logic        frame_err;
`ifdef UART_PARITY_EN
   logic        parity_err;
   int          pe_cnt = 0;
`endif

   int n_vec  = 0;
   int n_err  = 0;
   int bv_cnt = 0;
   int fe_cnt = 0;
   int bv0, fe0;
   logic hit_ok;

   uart_word_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) dut (
      .CLK_50M    (CLK_50M),
      .reset      (reset),
      .clear      (clear),
      .rx         (rx),
      .rx_full    (rx_full),
      .word       (word),
      .byte_valid (byte_valid),
`ifdef UART_PARITY_EN
      .parity_err (parity_err),
`endif
      .frame_err  (frame_err)
   );

   always #5 CLK_50M = ~CLK_50M;

   // Pulse monitor, sampled away from the active edge.
   always @(negedge CLK_50M) begin
      if (byte_valid === 1'b1) bv_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
`ifdef UART_PARITY_EN
      if (parity_err === 1'b1) pe_cnt++;
`endif
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_b, input logic par_flip);
      rx = 1'b0;
      repeat (BIT) @(posedge CLK_50M);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(posedge CLK_50M);
      end
`ifdef UART_PARITY_EN
      rx = (^b) ^ par_flip;
      repeat (BIT) @(posedge CLK_50M);
`else
      if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
      rx = stop_b;
      repeat (BIT) @(posedge CLK_50M);
      rx = 1'b1;
      repeat (BIT / 2) @(posedge CLK_50M);
   endtask

   task automatic pulse_clear();
      @(negedge CLK_50M);
      clear = 1'b1;
      @(negedge CLK_50M);
      clear = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge CLK_50M);
      #1;
      chk("rst_word", word, 32'h0);
      chk("rst_full", {31'b0, rx_full}, 32'h0);
      chk("rst_bv", {31'b0, byte_valid}, 32'h0);
      chk("rst_fe", {31'b0, frame_err}, 32'h0);
      reset = 1'b1;
      repeat (BIT) @(posedge CLK_50M);

      // Four bytes fill the word
      send_byte(8'h12, 1'b1, 1'b0);
      chk("w1", word, 32'h00000012);
      send_byte(8'h34, 1'b1, 1'b0);
      chk("w2", word, 32'h00001234);
      send_byte(8'h56, 1'b1, 1'b0);
      chk("w3", word, 32'h00123456);
      chk("full_after3", {31'b0, rx_full}, 32'h0);
      send_byte(8'h78, 1'b1, 1'b0);
      chk("w4", word, 32'h12345678);
      chk("full_after4", {31'b0, rx_full}, 32'h1);
      chk("bv_4", bv_cnt, 4);

      // Full: extra byte dropped silently
      send_byte(8'h9A, 1'b1, 1'b0);
      chk("full_drop_word", word, 32'h12345678);
      chk("full_drop_full", {31'b0, rx_full}, 32'h1);
      chk("full_drop_bv", bv_cnt, 4);

      // Clear, then a fresh byte
      pulse_clear();
      #1;
      chk("clr_word", word, 32'h0);
      chk("clr_full", {31'b0, rx_full}, 32'h0);
      send_byte(8'hAB, 1'b1, 1'b0);
      chk("after_clr", word, 32'h000000AB);
      chk("bv_5", bv_cnt, 5);

      // Framing error: byte discarded, count unchanged
      send_byte(8'h55, 1'b0, 1'b0);
      chk("fe_pulse", fe_cnt, 1);
      chk("fe_word", word, 32'h000000AB);
      chk("fe_bv", bv_cnt, 5);
      send_byte(8'h66, 1'b1, 1'b0);
      chk("after_fe", word, 32'h0000AB66);
      send_byte(8'h77, 1'b1, 1'b0);
      send_byte(8'h88, 1'b1, 1'b0);
      chk("fe_count_word", word, 32'hAB667788);
      chk("fe_count_full", {31'b0, rx_full}, 32'h1);

      // Short low glitch on an idle line is rejected
      pulse_clear();
      bv0 = bv_cnt;
      fe0 = fe_cnt;
      @(posedge CLK_50M);
      rx = 1'b0;
      repeat (2 * DIV) @(posedge CLK_50M);
      rx = 1'b1;
      repeat (2 * BIT) @(posedge CLK_50M);
      chk("glitch_bv", bv_cnt, bv0);
      chk("glitch_fe", fe_cnt, fe0);
      send_byte(8'h01, 1'b1, 1'b0);
      chk("after_glitch", word, 32'h00000001);
      chk("glitch_bv1", bv_cnt, bv0 + 1);

      // Clear lands on the acceptance cycle: clear wins
      bv0 = bv_cnt;
      hit_ok = 1'b0;
      fork
         send_byte(8'h5A, 1'b1, 1'b0);
         begin
            int k = 0;
            @(negedge CLK_50M);
            while (k < 12 * BIT && dut.stop_smp !== 1'b1) begin
               @(negedge CLK_50M);
               k++;
            end
            hit_ok = (k < 12 * BIT);
            clear = 1'b1;
            @(negedge CLK_50M);
            clear = 1'b0;
         end
      join
      chk("hit_found", {31'b0, hit_ok}, 32'h1);
      chk("hit_word", word, 32'h0);
      chk("hit_bv", bv_cnt, bv0);
      send_byte(8'h11, 1'b1, 1'b0);
      send_byte(8'h22, 1'b1, 1'b0);
      send_byte(8'h33, 1'b1, 1'b0);
      chk("hit_cnt_full3", {31'b0, rx_full}, 32'h0);
      send_byte(8'h44, 1'b1, 1'b0);
      chk("hit_cnt_word", word, 32'h11223344);
      chk("hit_cnt_full4", {31'b0, rx_full}, 32'h1);

      // Reset in the middle of a 0xFF frame
      rx = 1'b0;
      repeat (BIT) @(posedge CLK_50M);
      rx = 1'b1;
      repeat (3 * BIT) @(posedge CLK_50M);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_word", word, 32'h0);
      chk("mid_rst_full", {31'b0, rx_full}, 32'h0);
      chk("mid_rst_bv", {31'b0, byte_valid}, 32'h0);
      chk("mid_rst_fe", {31'b0, frame_err}, 32'h0);
      repeat (10) @(posedge CLK_50M);
      reset = 1'b1;
      repeat (BIT) @(posedge CLK_50M);
      bv0 = bv_cnt;
      fe0 = fe_cnt;
`ifdef UART_PARITY_EN
      send_byte(8'h42, 1'b1, 1'b1);
      chk("par_pulse", pe_cnt, 1);
      chk("par_word", word, 32'h0);
      chk("par_bv", bv_cnt, bv0);
`endif
      send_byte(8'h42, 1'b1, 1'b0);
      chk("post_rst_word", word, 32'h00000042);
      chk("post_rst_bv", bv_cnt, bv0 + 1);
      chk("post_rst_fe", fe_cnt, fe0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
